// File: rtl/decoder_nx_seq_pkg.sv
// Shared types and helpers for the decoder_nx_seq line decoder.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } dec_state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest select supported is 8 bits, so 256 lines is the ceiling.
    localparam int ONEHOT_MAX = 256;

    // One-hot of idx over n lines; all-zero when idx is not a valid line.
    function automatic logic [ONEHOT_MAX-1:0] onehot(input logic [7:0] idx, input int n);
        logic [ONEHOT_MAX-1:0] r;
        r = '0;
        if (int'(idx) < n) r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/decoder_nx_seq_scan_ctr.sv
// Dwell and line counter for SCAN mode. idx/wrap describe the line the
// top level should display on the following cycle; wrap flags the first
// cycle of line 0 after running past the last line.
module dec_scan_ctr #(
    parameter int SEL_W   = 2,
    parameter int NUM_OUT = 4,
    parameter int DWELL   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic             run,
    output logic [SEL_W-1:0] idx,
    output logic             wrap
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_OUT - 1);

    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             wrap_q, wrap_d;

    // Restart parks on line 0; run holds each line DWELL cycles then advances.
    always_comb begin
        dwell_d = dwell_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        if (restart) begin
            dwell_d = '0;
            idx_d   = '0;
        end else if (run) begin
            if (dwell_q == DW_LAST) begin
                dwell_d = '0;
                if (idx_q == IDX_LAST) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q <= '0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            dwell_q <= dwell_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
        end
    end

    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/decoder_nx_seq.sv
// Registered SEL_W-to-NUM_OUT one-hot decoder with DIRECT (handshaked
// select) and SCAN (self-walking) modes. Define DECODE_ERR_EN to reject
// out-of-range selects and report them on err.
module decoder_nx_seq
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int NUM_OUT = 4,
    parameter int DWELL   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_OUT-1:0] y,
    output logic               y_valid,
    output logic [SEL_W-1:0]   cur_idx,
    output logic               wrap
`ifdef DECODE_ERR_EN
    ,
    output logic               err
`endif
);

    dec_state_t         state_q, state_d;
    logic [NUM_OUT-1:0] y_q, y_d;
    logic               y_valid_q, y_valid_d;
    logic [SEL_W-1:0]   cur_idx_q, cur_idx_d;
    logic               wrap_q, wrap_d;
    logic [SEL_W-1:0]   scan_idx;
    logic               scan_wrap;
    logic               accept;

`ifdef DECODE_ERR_EN
    logic err_q, err_d;
    logic oor;
    // Constant 0 when every select code maps to a line.
    assign oor    = {1'b0, sel} >= (SEL_W+1)'(NUM_OUT);
    assign accept = !oor;
`else
    assign accept = 1'b1;
`endif

    dec_scan_ctr #(
        .SEL_W   (SEL_W),
        .NUM_OUT (NUM_OUT),
        .DWELL   (DWELL)
    ) u_scan_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (!en || state_q != SCAN),
        .run     (en && state_q == SCAN && mode == MODE_SCAN),
        .idx     (scan_idx),
        .wrap    (scan_wrap)
    );

    // Next-state and next-output logic; en low overrides everything.
    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        cur_idx_d = cur_idx_q;
        wrap_d    = 1'b0;
`ifdef DECODE_ERR_EN
        err_d     = 1'b0;
`endif
        if (!en) begin
            state_d   = IDLE;
            y_d       = '0;
            y_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = (mode == MODE_SCAN) ? SCAN : DIRECT;
                DIRECT: begin
                    if (in_valid && accept) begin
                        y_d       = NUM_OUT'(onehot(8'(sel), NUM_OUT));
                        y_valid_d = 1'b1;
                        cur_idx_d = sel;
                    end
`ifdef DECODE_ERR_EN
                    err_d = in_valid && oor;
`endif
                    // A transfer in the flip cycle still lands; SCAN starts after.
                    if (mode == MODE_SCAN) state_d = SCAN;
                end
                SCAN: begin
                    if (mode == MODE_SCAN) begin
                        y_d       = NUM_OUT'(onehot(8'(scan_idx), NUM_OUT));
                        y_valid_d = 1'b1;
                        cur_idx_d = scan_idx;
                        wrap_d    = scan_wrap;
                    end else begin
                        state_d = DIRECT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            cur_idx_q <= '0;
            wrap_q    <= 1'b0;
`ifdef DECODE_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            cur_idx_q <= cur_idx_d;
            wrap_q    <= wrap_d;
`ifdef DECODE_ERR_EN
            err_q     <= err_d;
`endif
        end
    end

    assign in_ready = (state_q == DIRECT);
    assign y        = y_q;
    assign y_valid  = y_valid_q;
    assign cur_idx  = cur_idx_q;
    assign wrap     = wrap_q;
`ifdef DECODE_ERR_EN
    assign err      = err_q;
`endif

endmodule
